cmd_rsp_regs: RTL

- Responder end of the 2-bit cmd / 8-bit addr / 32-bit data register command bus; the initiator drives that bus and this block answers it.
- Small memory-mapped register bank: ID, scratch, control, W1C status and saturating access counters.
- Sits behind the initiator in the block-level bench and in the control subsystem.
- Exports control bits to the datapath.

---
 rtl/cmd_bus_pkg.sv | 27 ++
 rtl/sat_cnt.sv | 31 +++
 rtl/cmd_rsp_regs.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cmd_bus_pkg.sv
// Shared definitions for the cmd/addr/data register bus: command encodings,
// register addresses, STAT bit positions and the LOCK key.
package cmd_bus_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_RD   = 2'b01,
        CMD_WR   = 2'b10,
        CMD_ILL  = 2'b11
    } cmd_e;

    localparam logic [7:0] ADDR_ID      = 8'h00;
    localparam logic [7:0] ADDR_SCRATCH = 8'h04;
    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STAT    = 8'h0C;
    localparam logic [7:0] ADDR_WR_CNT  = 8'h10;
    localparam logic [7:0] ADDR_RD_CNT  = 8'h14;
    localparam logic [7:0] ADDR_ERR_CNT = 8'h18;
    localparam logic [7:0] ADDR_LOCK    = 8'h1C;

    localparam int STAT_ILL   = 0;
    localparam int STAT_UNMAP = 1;
    localparam int STAT_RO    = 2;

    localparam logic [31:0] LOCK_KEY = 32'h0000_005A;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clr_i has priority.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cmd_rsp_regs.sv
// Responder register bank for the cmd/addr/data bus: ID, SCRATCH, CTRL, W1C STAT
// and saturating counters. Define RSP_LOCK_EN to add the LOCK register at 0x1C.
module cmd_rsp_regs
    import cmd_bus_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h0001_0100,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
    parameter int          CNT_W    = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [1:0]  cmd_i,
    input  logic [7:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic [31:0] cmd_data_o,
    output logic        ctrl_en_o,
    output logic [2:0]  ctrl_mode_o,
    output logic        start_pulse_o
);

    cmd_e        cmd;
    logic        isRd, isWr, isIll;
    logic        mapped, roReg, lockable;
    logic        roWrErr, unmapErr, errCycle;
    logic        locked;
    logic [31:0] readVal;
    logic [31:0] wrCnt32, rdCnt32;
    logic [2:0]  statSet, statClr;

    logic [31:0] rdata_q, rdata_d;
    logic [31:0] scratch_q, scratch_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [2:0]  stat_q, stat_d;
    logic        startPulse_q, startPulse_d;

    logic [CNT_W-1:0] wrCnt, rdCnt;
    logic [7:0]       errCnt;

    assign cmd   = cmd_e'(cmd_i);
    assign isRd  = (cmd == CMD_RD);
    assign isWr  = (cmd == CMD_WR);
    assign isIll = (cmd == CMD_ILL);

`ifdef RSP_LOCK_EN
    logic lock_q, lock_d;

    // Lock is sticky until reset; only the exact key value sets it.
    assign lock_d = lock_q | (isWr && (cmd_addr_i == ADDR_LOCK) && (cmd_data_i == LOCK_KEY));

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        wrCnt32 = '0;
        rdCnt32 = '0;
        wrCnt32[CNT_W-1:0] = wrCnt;
        rdCnt32[CNT_W-1:0] = rdCnt;
    end

    // Decode; misaligned addresses never match an entry so they fall to unmapped.
    always_comb begin
        mapped   = 1'b1;
        roReg    = 1'b0;
        lockable = 1'b0;
        readVal  = ERR_DATA;
        case (cmd_addr_i)
            ADDR_ID:      begin readVal = ID_VALUE;                 roReg = 1'b1; end
            ADDR_SCRATCH: begin readVal = scratch_q;                lockable = 1'b1; end
            ADDR_CTRL:    begin readVal = {28'd0, ctrl_q};          lockable = 1'b1; end
            ADDR_STAT:    begin readVal = {29'd0, stat_q};          end
            ADDR_WR_CNT:  begin readVal = wrCnt32;                  roReg = 1'b1; end
            ADDR_RD_CNT:  begin readVal = rdCnt32;                  roReg = 1'b1; end
            ADDR_ERR_CNT: begin readVal = {24'd0, errCnt};          roReg = 1'b1; end
`ifdef RSP_LOCK_EN
            ADDR_LOCK:    begin readVal = {31'd0, locked};          end
`endif
            default:      begin mapped = 1'b0;                      end
        endcase
    end

    always_comb begin
        roWrErr  = isWr && mapped && (roReg || (locked && lockable));
        unmapErr = (isRd || isWr) && !mapped;
        errCycle = isIll || unmapErr || roWrErr;

        statSet             = '0;
        statSet[STAT_ILL]   = isIll;
        statSet[STAT_UNMAP] = unmapErr;
        statSet[STAT_RO]    = roWrErr;
        statClr = (isWr && (cmd_addr_i == ADDR_STAT)) ? cmd_data_i[2:0] : 3'b000;
        // Set is applied after the clear so a simultaneous set wins.
        stat_d = (stat_q & ~statClr) | statSet;

        scratch_d    = scratch_q;
        ctrl_d       = ctrl_q;
        startPulse_d = 1'b0;
        if (isWr && !locked && (cmd_addr_i == ADDR_SCRATCH)) begin
            scratch_d = cmd_data_i;
        end
        if (isWr && !locked && (cmd_addr_i == ADDR_CTRL)) begin
            ctrl_d       = cmd_data_i[3:0];
            startPulse_d = cmd_data_i[8];
        end

        rdata_d = isRd ? readVal : rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rdata_q      <= '0;
            scratch_q    <= '0;
            ctrl_q       <= '0;
            stat_q       <= '0;
            startPulse_q <= 1'b0;
        end else begin
            rdata_q      <= rdata_d;
            scratch_q    <= scratch_d;
            ctrl_q       <= ctrl_d;
            stat_q       <= stat_d;
            startPulse_q <= startPulse_d;
        end
    end

    sat_cnt #(.W(CNT_W)) uWrCnt (
        .clk_i (clk_i),
        .clr_i (!rstn_i),
        .inc_i (isWr),
        .cnt_o (wrCnt)
    );

    sat_cnt #(.W(CNT_W)) uRdCnt (
        .clk_i (clk_i),
        .clr_i (!rstn_i),
        .inc_i (isRd),
        .cnt_o (rdCnt)
    );

    sat_cnt #(.W(8)) uErrCnt (
        .clk_i (clk_i),
        .clr_i (!rstn_i),
        .inc_i (errCycle),
        .cnt_o (errCnt)
    );

    assign cmd_data_o    = rdata_q;
    assign ctrl_en_o     = ctrl_q[0];
    assign ctrl_mode_o   = ctrl_q[3:1];
    assign start_pulse_o = startPulse_q;

endmodule
